// File: rtl/ad_align_ctrl.sv
// ad_align_ctrl: read-side sequencer for NCH parallel ADC CDC FIFOs.
// Flushes the FIFOs, lets the write side settle, waits for every channel to
// reach START_LVL, then releases one common read enable with a sync pulse.
// Faults while streaming are counted and trigger an automatic realign.
// Optional build macro: AD_ALIGN_SKEW_CHK_EN adds a registered level-spread check.
module ad_align_ctrl #(
    parameter int unsigned NCH        = 2,
    parameter int unsigned LVL_W      = 10,
    parameter int unsigned START_LVL  = 10,
    parameter int unsigned LOW_LVL    = 2,
    parameter int unsigned FLUSH_CYC  = 4,
    parameter int unsigned SETTLE_CYC = 32,
    parameter int unsigned SKEW_MAX   = 4
) (
    input  logic               i_ad_gclk,
    input  logic               rst_n,
    input  logic               i_enable,
    input  logic               i_realign,
    input  logic [NCH*LVL_W-1:0] i_ff_rdusedw,
    input  logic [NCH-1:0]     i_ff_empty,
    input  logic [NCH-1:0]     i_ff_full,
    output logic               o_ff_aclr,
    output logic               o_ff_rden,
    output logic               o_dout_vl,
    output logic               o_sync_out,
    output logic               o_locked,
    output logic [2:0]         o_state,
    output logic [15:0]        o_err_cnt,
    output logic               o_skew_err
);

    localparam int unsigned CntMax = (FLUSH_CYC > SETTLE_CYC) ? FLUSH_CYC : SETTLE_CYC;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0]  FlushLast  = CntW'(FLUSH_CYC - 1);
    localparam logic [CntW-1:0]  SettleLast = CntW'(SETTLE_CYC - 1);
    localparam logic [LVL_W-1:0] StartLvl   = LVL_W'(START_LVL);
    localparam logic [LVL_W-1:0] LowLvl     = LVL_W'(LOW_LVL);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFlush  = 3'd1,
        StSettle = 3'd2,
        StFill   = 3'd3,
        StRun    = 3'd4,
        StError  = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            cnt_restart;
    logic            aclr_q, aclr_d;
    logic            rden_q, rden_d;
    logic            vl_q;
    logic            sync_q, sync_d;
    logic            locked_q, locked_d;
    logic [15:0]     err_q, err_d;
    logic            skew_err_q, skew_err_d;
    logic            all_ready, any_low, skew_fault, run_fault;

    // Per-channel level scan: readiness for FILL and underrun for RUN
    always_comb begin
        all_ready = 1'b1;
        any_low   = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            logic [LVL_W-1:0] lvl;
            lvl = i_ff_rdusedw[k*LVL_W +: LVL_W];
            if (lvl < StartLvl) all_ready = 1'b0;
            if (lvl < LowLvl)   any_low   = 1'b1;
        end
    end

`ifdef AD_ALIGN_SKEW_CHK_EN
    localparam logic [LVL_W-1:0] SkewMax = LVL_W'(SKEW_MAX);

    logic [LVL_W-1:0] lvl_max_d, lvl_min_d, lvl_max_q, lvl_min_q;

    // Max/min compare tree over all channel levels
    always_comb begin
        lvl_max_d = i_ff_rdusedw[LVL_W-1:0];
        lvl_min_d = i_ff_rdusedw[LVL_W-1:0];
        for (int k = 1; k < NCH; k++) begin
            if (i_ff_rdusedw[k*LVL_W +: LVL_W] > lvl_max_d) lvl_max_d = i_ff_rdusedw[k*LVL_W +: LVL_W];
            if (i_ff_rdusedw[k*LVL_W +: LVL_W] < lvl_min_d) lvl_min_d = i_ff_rdusedw[k*LVL_W +: LVL_W];
        end
    end

    // Register the extremes; the spread check then lags the levels by one cycle
    always_ff @(posedge i_ad_gclk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_max_q <= '0;
            lvl_min_q <= '0;
        end else begin
            lvl_max_q <= lvl_max_d;
            lvl_min_q <= lvl_min_d;
        end
    end

    assign skew_fault = ((lvl_max_q - lvl_min_q) > SkewMax);
    assign skew_err_d = skew_err_q | ((state_q == StRun) && skew_fault);
`else
    assign skew_fault = 1'b0;
    assign skew_err_d = 1'b0;
`endif

    assign run_fault = any_low | (|i_ff_empty) | (|i_ff_full) | skew_fault;

    // Next-state: enable drop beats realign, realign beats normal flow
    always_comb begin
        state_d     = state_q;
        cnt_restart = 1'b0;
        if (!i_enable) begin
            state_d = StIdle;
        end else if (i_realign && (state_q != StIdle)) begin
            state_d     = StFlush;
            cnt_restart = 1'b1;
        end else begin
            unique case (state_q)
                StIdle:   state_d = StFlush;
                StFlush:  if (cnt_q == FlushLast) state_d = StSettle;
                StSettle: if (cnt_q == SettleLast) state_d = StFill;
                StFill:   if (all_ready) state_d = StRun;
                StRun:    if (run_fault) state_d = StError;
                StError:  state_d = StFlush;
                default:  state_d = StIdle;
            endcase
        end
    end

    // Phase counter and registered-output next values, all decoded from state_d
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_restart || (state_d != state_q)) begin
            cnt_d = '0;
        end else if ((state_q == StFlush) || (state_q == StSettle)) begin
            cnt_d = cnt_q + CntW'(1);
        end
        aclr_d   = (state_d == StFlush);
        rden_d   = (state_d == StRun);
        locked_d = (state_d == StRun);
        sync_d   = (state_d == StRun) && (state_q != StRun);
        err_d    = err_q;
        if ((state_d == StError) && (state_q != StError) && (err_q != 16'hFFFF)) begin
            err_d = err_q + 16'd1;
        end
    end

    // State and output registers; async reset clears everything
    always_ff @(posedge i_ad_gclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            aclr_q     <= 1'b0;
            rden_q     <= 1'b0;
            vl_q       <= 1'b0;
            sync_q     <= 1'b0;
            locked_q   <= 1'b0;
            err_q      <= '0;
            skew_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            aclr_q     <= aclr_d;
            rden_q     <= rden_d;
            vl_q       <= rden_q;
            sync_q     <= sync_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
            skew_err_q <= skew_err_d;
        end
    end

    assign o_ff_aclr  = aclr_q;
    assign o_ff_rden  = rden_q;
    assign o_dout_vl  = vl_q;
    assign o_sync_out = sync_q;
    assign o_locked   = locked_q;
    assign o_state    = state_q;
    assign o_err_cnt  = err_q;
    assign o_skew_err = skew_err_q;

endmodule
